// File: rtl/uart_rx_frame_sr.sv
// UART receive frame shifter.
// Deserialises one LSB-first frame (data, optional parity, one or two stop
// bits) under control of an external bit-sample strobe. At the end of the
// frame it registers the data word and the parity/framing flags together,
// and pulses frame_done for one cycle.
module uart_rx_frame_sr #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 shift_enable,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] packet_data,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int FRAME_LEN = DATA_BITS + PARITY_EN + STOP_BITS;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [CNT_W-1:0]     r_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_frame_err;

    logic [DATA_BITS-1:0] r_packet;
    logic                 r_parity_error;
    logic                 r_framing_error;
    logic                 r_frame_done;

    // Per-cycle control decoded from the state and the strobes.
    logic                 w_clear;
    logic                 w_shift;
    logic                 w_par_cap;
    logic                 w_stop;
    logic                 w_commit;
    logic                 w_par_exp;
    logic                 w_par_err;

    // Expected parity over the received word; only meaningful when parity is on.
    assign w_par_exp = (^r_shift) ^ (PARITY_ODD != 0);
    assign w_par_err = (PARITY_EN != 0) && (r_par_bit != w_par_exp);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode; start overrides any sample in the same cycle.
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_shift      = 1'b0;
        w_par_cap    = 1'b0;
        w_stop       = 1'b0;
        w_commit     = 1'b0;
        if (start) begin
            w_next_state = S_DATA;
            w_clear      = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                end
                S_DATA: begin
                    if (shift_enable) begin
                        w_shift = 1'b1;
                        if (r_cnt == LAST_DATA) begin
                            w_next_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (shift_enable) begin
                        w_par_cap    = 1'b1;
                        w_next_state = S_STOP;
                    end
                end
                S_STOP: begin
                    if (shift_enable) begin
                        w_stop = 1'b1;
                        if (r_cnt == LAST_BIT) begin
                            w_commit     = 1'b1;
                            w_next_state = S_IDLE;
                        end
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Frame datapath: bit counter, shift register, captured parity and stop flags,
    // and the committed output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt           <= '0;
            r_shift         <= '0;
            r_par_bit       <= 1'b0;
            r_frame_err     <= 1'b0;
            r_packet        <= '0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            r_frame_done <= w_commit;
            if (w_clear) begin
                r_cnt       <= '0;
                r_shift     <= '0;
                r_par_bit   <= 1'b0;
                r_frame_err <= 1'b0;
            end else begin
                if (w_shift || w_par_cap || w_stop) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_shift) begin
                    r_shift <= {serial_in, r_shift[DATA_BITS-1:1]};
                end
                if (w_par_cap) begin
                    r_par_bit <= serial_in;
                end
                if (w_stop && !serial_in) begin
                    r_frame_err <= 1'b1;
                end
            end
            // The final stop sample is folded in directly since it is not yet registered.
            if (w_commit) begin
                r_packet        <= r_shift;
                r_parity_error  <= w_par_err;
                r_framing_error <= r_frame_err | ~serial_in;
            end
        end
    end

    assign packet_data   = r_packet;
    assign parity_error  = r_parity_error;
    assign framing_error = r_framing_error;
    assign frame_done    = r_frame_done;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_sr.sv
// Testbench for uart_rx_frame_sr: a default instance (8 data, even parity,
// 1 stop) and a 7-data / no-parity / 2-stop instance. Expected words and
// flags are queued when a frame is sent and compared when frame_done fires.
module tb_uart_rx_frame_sr;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: defaults.
    logic       a_start, a_se, a_sin;
    logic [7:0] a_packet_data;
    logic       a_parity_error, a_framing_error, a_frame_done, a_busy;

    // Instance B: 7 data bits, no parity, 2 stop bits.
    logic       b_start, b_se, b_sin;
    logic [6:0] b_packet_data;
    logic       b_parity_error, b_framing_error, b_frame_done, b_busy;

    uart_rx_frame_sr u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .start        (a_start),
        .shift_enable (a_se),
        .serial_in    (a_sin),
        .packet_data  (a_packet_data),
        .parity_error (a_parity_error),
        .framing_error(a_framing_error),
        .frame_done   (a_frame_done),
        .busy         (a_busy)
    );

    uart_rx_frame_sr #(
        .DATA_BITS (7),
        .PARITY_EN (0),
        .PARITY_ODD(0),
        .STOP_BITS (2)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .start        (b_start),
        .shift_enable (b_se),
        .serial_in    (b_sin),
        .packet_data  (b_packet_data),
        .parity_error (b_parity_error),
        .framing_error(b_framing_error),
        .frame_done   (b_frame_done),
        .busy         (b_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int a_done_cnt = 0;
    int b_done_cnt = 0;

    // Scoreboard entries: {data[8:0], parity_error, framing_error}.
    logic [10:0] a_q[$];
    logic [10:0] b_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard monitors: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (a_frame_done === 1'b1) begin
            logic [10:0] e;
            a_done_cnt++;
            check("a_sb_pending", 32'(a_q.size() != 0), 1);
            if (a_q.size() != 0) begin
                e = a_q.pop_front();
                check("a_data", 32'(a_packet_data), 32'(e[9:2]));
                check("a_parity_error", 32'(a_parity_error), 32'(e[1]));
                check("a_framing_error", 32'(a_framing_error), 32'(e[0]));
            end
        end
        if (b_frame_done === 1'b1) begin
            logic [10:0] e;
            b_done_cnt++;
            check("b_sb_pending", 32'(b_q.size() != 0), 1);
            if (b_q.size() != 0) begin
                e = b_q.pop_front();
                check("b_data", 32'(b_packet_data), 32'(e[8:2]));
                check("b_parity_error", 32'(b_parity_error), 32'(e[1]));
                check("b_framing_error", 32'(b_framing_error), 32'(e[0]));
            end
        end
    end

    // All driving tasks are entered just after a falling edge and return just after one.
    task automatic start_pulse(input bit sel);
        if (sel) b_start = 1'b1; else a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic strobe(input bit sel, input logic b);
        if (sel) begin b_se = 1'b1; b_sin = b; end
        else     begin a_se = 1'b1; a_sin = b; end
        @(negedge clk);
        a_se = 1'b0;
        b_se = 1'b0;
    endtask

    // Sends data, optional parity and the stop bits, queueing the expected result.
    // On return the final sample has just been taken and frame_done should be visible.
    task automatic send_body(input bit sel, input logic [8:0] data, input int nbits,
                             input bit par_en, input logic par, input logic [1:0] stops,
                             input int nstops, input bit gaps);
        logic perr_exp;
        logic ferr_exp;
        logic par_calc;
        par_calc = 1'b0;
        for (int i = 0; i < nbits; i++) par_calc = par_calc ^ data[i];
        perr_exp = par_en ? (par != par_calc) : 1'b0;
        ferr_exp = 1'b0;
        for (int i = 0; i < nstops; i++) if (!stops[i]) ferr_exp = 1'b1;
        if (sel) b_q.push_back({data, perr_exp, ferr_exp});
        else     a_q.push_back({data, perr_exp, ferr_exp});
        for (int i = 0; i < nbits; i++) begin
            strobe(sel, data[i]);
            if (gaps) @(negedge clk);
        end
        if (par_en) begin
            strobe(sel, par);
            if (gaps) @(negedge clk);
        end
        for (int i = 0; i < nstops; i++) begin
            strobe(sel, stops[i]);
            if (gaps && i < nstops - 1) @(negedge clk);
        end
    endtask

    int base;

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_se = 1'b0; a_sin = 1'b1;
        b_start = 1'b0; b_se = 1'b0; b_sin = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        check("rst_a_data", 32'(a_packet_data), 0);
        check("rst_a_perr", 32'(a_parity_error), 0);
        check("rst_a_ferr", 32'(a_framing_error), 0);
        check("rst_a_done", 32'(a_frame_done), 0);
        check("rst_a_busy", 32'(a_busy), 0);
        check("rst_b_busy", 32'(b_busy), 0);

        // Clean 0xA5 frame, spaced strobes.
        start_pulse(0);
        check("a5_busy", 32'(a_busy), 1);
        send_body(0, 9'h0A5, 8, 1, 1'b0, 2'b11, 1, 1);
        check("a5_done", 32'(a_frame_done), 1);
        check("a5_busy_after", 32'(a_busy), 0);
        @(negedge clk);
        check("a5_done_one_cycle", 32'(a_frame_done), 0);
        check("a5_hold", 32'(a_packet_data), 32'h0A5);

        // Wrong parity bit, consecutive strobes.
        start_pulse(0);
        send_body(0, 9'h0A5, 8, 1, 1'b1, 2'b11, 1, 0);
        check("perr_done", 32'(a_frame_done), 1);

        // Bad stop bit, then a back-to-back clean 0x3C frame (start in the done cycle).
        start_pulse(0);
        send_body(0, 9'h0A5, 8, 1, 1'b0, 2'b10, 1, 0);
        check("ferr_done", 32'(a_frame_done), 1);
        start_pulse(0);
        check("b2b_busy", 32'(a_busy), 1);
        send_body(0, 9'h03C, 8, 1, 1'b0, 2'b11, 1, 0);
        check("3c_done", 32'(a_frame_done), 1);
        @(negedge clk);

        // Abort after 4 data bits with start coincident with a sample; then 0x5A.
        base = a_done_cnt;
        start_pulse(0);
        for (int i = 0; i < 4; i++) strobe(0, 1'b1);
        a_start = 1'b1; a_se = 1'b1; a_sin = 1'b0;
        @(negedge clk);
        a_start = 1'b0; a_se = 1'b0;
        check("abort_busy", 32'(a_busy), 1);
        check("abort_no_done", 32'(a_frame_done), 0);
        check("abort_hold_data", 32'(a_packet_data), 32'h03C);
        check("abort_hold_ferr", 32'(a_framing_error), 0);
        send_body(0, 9'h05A, 8, 1, 1'b0, 2'b11, 1, 1);
        @(negedge clk);
        check("abort_one_done", 32'(a_done_cnt - base), 1);

        // Reset mid-frame after 5 data bits, then strobes without start.
        start_pulse(0);
        for (int i = 0; i < 5; i++) strobe(0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(a_busy), 0);
        check("midrst_data", 32'(a_packet_data), 0);
        check("midrst_perr", 32'(a_parity_error), 0);
        check("midrst_ferr", 32'(a_framing_error), 0);
        check("midrst_done", 32'(a_frame_done), 0);
        base = a_done_cnt;
        for (int i = 0; i < 12; i++) strobe(0, 1'b1);
        @(negedge clk);
        check("midrst_no_done", 32'(a_done_cnt - base), 0);
        check("midrst_still_idle", 32'(a_busy), 0);

        // Instance B: 7 data bits 0,0,1,1,1,1,0 (7'h3C), stops 1 then 0.
        start_pulse(1);
        for (int i = 0; i < 7; i++) strobe(1, (7'h3C >> i) & 1'b1);
        b_q.push_back({9'h03C, 1'b0, 1'b1});
        strobe(1, 1'b1);
        check("b_no_done_8th", 32'(b_frame_done), 0);
        check("b_busy_8th", 32'(b_busy), 1);
        strobe(1, 1'b0);
        check("b_done_9th", 32'(b_frame_done), 1);
        check("b_busy_after", 32'(b_busy), 0);
        @(negedge clk);

        // Instance B: clean 7'h55 frame with spaced strobes.
        start_pulse(1);
        send_body(1, 9'h055, 7, 0, 1'b0, 2'b11, 2, 1);
        check("b55_done", 32'(b_frame_done), 1);
        @(negedge clk);

        check("a_sb_drained", 32'(a_q.size()), 0);
        check("b_sb_drained", 32'(b_q.size()), 0);
        check("a_done_total", 32'(a_done_cnt), 5);
        check("b_done_total", 32'(b_done_cnt), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_sr.md
# uart_rx_frame_sr

Parametrised UART receive frame shifter for the APB-slave UART receiver peripheral. It deserialises one frame LSB-first: configurable data width, optional parity, and one or two stop bits. It tracks frame position with an internal bit counter and checks parity and stop bits. Completed words and error flags are presented to the RX FIFO/register file with a one-cycle `frame_done` strobe.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `PARITY_EN`, default 1: 1 means a parity bit follows the data bits; 0 means no parity bit.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse from the start-bit detector: a new frame begins (start bit already consumed).
- `shift_enable`  in  1  single-cycle bit-sample strobe from the timer, one per bit period.
- `serial_in`  in  1  synchronised RX line.
- `packet_data`  out  `DATA_BITS`  last completed data word; bit 0 is the first bit received.
- `parity_error`  out  1  parity mismatch in the last completed frame.
- `framing_error`  out  1  any stop bit of the last completed frame sampled 0.
- `frame_done`  out  1  one-cycle strobe: outputs updated with a new frame.
- `busy`  out  1  frame in progress (state is not IDLE).

## Operation
- FSM states: IDLE, DATA, PARITY, STOP. FRAME_LEN = `DATA_BITS` + `PARITY_EN` + `STOP_BITS`; the bit counter is wide enough for FRAME_LEN.
- IDLE: `shift_enable` is ignored. `start` clears the counter and shift register and enters DATA.
- DATA: each `shift_enable` shifts `serial_in` in at the MSB end with a right shift, so the first bit ends at bit 0, and increments the counter. After `DATA_BITS` samples, go to PARITY if `PARITY_EN`, else STOP.
- PARITY: one `shift_enable` captures the parity bit, then go to STOP.
  - Even parity: expected bit = XOR of the data bits.
  - Odd parity: expected bit = inverted XOR.
- STOP: each `shift_enable` samples one stop bit. A 0 sample sets the internal framing flag. After `STOP_BITS` samples, commit and return to IDLE.
- Commit: `packet_data`, `parity_error` (forced 0 when `PARITY_EN`=0) and `framing_error` are loaded together, and `frame_done` pulses. All three hold until the next commit.
- `start` while `busy`: the current frame is abandoned with no commit and no `frame_done`. The counter and shift register clear and the FSM re-enters DATA. Committed outputs are unchanged.
- `start` and `shift_enable` in the same cycle: `start` wins and the sample is discarded.
- `rst` (any state, mid-frame included): FSM to IDLE; counter, shift register and all outputs cleared.

## Timing
- Reset values: `packet_data`=0, `parity_error`=0, `framing_error`=0, `frame_done`=0, `busy`=0.
- `busy` is high from the cycle after `start` until the cycle after the final stop-bit sample.
- Final stop-bit `shift_enable` in cycle t: `frame_done`=1 in cycle t+1 only, with new data and flags visible in t+1. `busy`=0 in t+1.
- A `start` in cycle t+1 is accepted; back-to-back frames need no idle cycle.
- `shift_enable` may be asserted in consecutive cycles; there is no minimum spacing.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Defaults (8 data, even parity, 1 stop). Send `start`, then bits 1,0,1,0,0,1,0,1 (0xA5), parity 0, stop 1 -> one `frame_done` cycle after the last strobe; `packet_data`=0xA5, both error flags 0.
- Same frame with parity bit 1 -> `packet_data`=0xA5, `parity_error`=1, `framing_error`=0.
- Same frame with stop bit 0 -> `framing_error`=1, `parity_error`=0. A following clean 0x3C frame -> both flags clear, `packet_data`=0x3C.
- `DATA_BITS`=7, `PARITY_EN`=0, `STOP_BITS`=2. Send 0,0,1,1,1,1,0 then stops 1,0 -> `packet_data`=7'h3C, `framing_error`=1, `parity_error`=0. `frame_done` asserts only after the 9th strobe.
- Abort: after 4 data bits, pulse `start` coincident with `shift_enable`, then send a full 0x5A frame -> exactly one `frame_done` with `packet_data`=0x5A; the previous outputs hold until then.
- Assert `rst` after 5 data bits -> next cycle `busy`=0 and all outputs 0. Further `shift_enable` pulses with no `start` -> no `frame_done`.
